// File: rtl/clause_update_sequencer_pkg.sv
// Shared types and constants for the clause-memory update sequencer.
// Optional feature macro: CLAUSE_UPD_FAIR_EN (starvation-aware arbitration).
package clause_update_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  localparam logic GRANT_RE  = 1'b1;
  localparam logic GRANT_SLW = 1'b0;

  localparam int unsigned SETTLE_MIN   = 1;
  localparam int unsigned SETTLE_MAX   = 15;
  localparam int unsigned SETTLE_CNT_W = 4;

  function automatic bit settle_ok(input int unsigned cycles);
    return (cycles >= SETTLE_MIN) && (cycles <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/clause_update_sequencer_arb.sv
// Two-way RE/SLW priority pick; with CLAUSE_UPD_FAIR_EN a registered
// starvation flag lets SLW win a tie after RE was granted over it.
module clause_upd_arb
  import clause_update_sequencer_pkg::*;
(
`ifdef CLAUSE_UPD_FAIR_EN
  input  logic clk,
  input  logic rst,
  input  logic grant_fire,
`endif
  input  logic re_req,
  input  logic slw_req,
  output logic pick_re_c
);

  logic slw_wins;

`ifdef CLAUSE_UPD_FAIR_EN
  logic starve;

  assign slw_wins = slw_req & (~re_req | starve);

  // Flag records an RE grant that bypassed a waiting SLW; cleared once SLW is served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= 1'b0;
    end else if (grant_fire) begin
      if (pick_re_c == GRANT_RE) begin
        if (slw_req) starve <= 1'b1;
      end else begin
        starve <= 1'b0;
      end
    end
  end
`else
  assign slw_wins = slw_req & ~re_req;
`endif

  assign pick_re_c = slw_wins ? GRANT_SLW : GRANT_RE;

endmodule

// File: rtl/clause_update_sequencer.sv
// Arbitrates RE vs SLW clause updates, holds the mux select for a settle
// window, strobes mem_we and acks the requester. Macro: CLAUSE_UPD_FAIR_EN.
module clause_update_sequencer
  import clause_update_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re_req,
  input  logic             slw_req,
  input  logic             hold,
  output logic             re_ack,
  output logic             slw_ack,
  output logic             update_from_re_update_module,
  output logic             update_from_sliding_window,
  output logic             mem_we,
  output logic             busy,
  output logic             grant_src,
  output logic [CNT_W-1:0] upd_count
);

  if (!settle_ok(SETTLE_CYCLES)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state, state_n;
  logic [SETTLE_CNT_W-1:0] cnt, cnt_n;
  logic                    grant_n;
  logic [CNT_W-1:0]        count_n;
  logic                    start_c;
  logic                    pick_re_c;
  logic                    sel_re_n, sel_slw_n, we_n, re_ack_n, slw_ack_n, busy_n;

  assign start_c = (state == ST_IDLE) && !hold && (re_req || slw_req);

  clause_upd_arb u_arb (
`ifdef CLAUSE_UPD_FAIR_EN
    .clk        (clk),
    .rst        (rst),
    .grant_fire (start_c),
`endif
    .re_req     (re_req),
    .slw_req    (slw_req),
    .pick_re_c  (pick_re_c)
  );

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_n = grant_src;
    count_n = upd_count;
    unique case (state)
      ST_IDLE: begin
        if (start_c) begin
          grant_n = pick_re_c;
          cnt_n   = SETTLE_LOAD;
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_n = ST_WRITE;
          count_n = upd_count + CNT_W'(1);
        end else begin
          cnt_n = cnt - SETTLE_CNT_W'(1);
        end
      end
      ST_WRITE: state_n = ST_ACK;
      ST_ACK:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    sel_re_n  = ((state_n == ST_SETTLE) || (state_n == ST_WRITE)) && (grant_n == GRANT_RE);
    sel_slw_n = ((state_n == ST_SETTLE) || (state_n == ST_WRITE)) && (grant_n == GRANT_SLW);
    we_n      = (state_n == ST_WRITE);
    re_ack_n  = (state_n == ST_ACK) && (grant_n == GRANT_RE);
    slw_ack_n = (state_n == ST_ACK) && (grant_n == GRANT_SLW);
    busy_n    = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                        <= ST_IDLE;
      cnt                          <= '0;
      grant_src                    <= 1'b0;
      upd_count                    <= '0;
      update_from_re_update_module <= 1'b0;
      update_from_sliding_window   <= 1'b0;
      mem_we                       <= 1'b0;
      re_ack                       <= 1'b0;
      slw_ack                      <= 1'b0;
      busy                         <= 1'b0;
    end else begin
      state                        <= state_n;
      cnt                          <= cnt_n;
      grant_src                    <= grant_n;
      upd_count                    <= count_n;
      update_from_re_update_module <= sel_re_n;
      update_from_sliding_window   <= sel_slw_n;
      mem_we                       <= we_n;
      re_ack                       <= re_ack_n;
      slw_ack                      <= slw_ack_n;
      busy                         <= busy_n;
    end
  end

endmodule

// File: tb/tb_clause_update_sequencer.sv
// Directed and randomized-protocol bench for clause_update_sequencer (SETTLE_CYCLES=2).
module tb_clause_update_sequencer;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             re_req;
  logic             slw_req;
  logic             hold;
  logic             re_ack;
  logic             slw_ack;
  logic             sel_re;
  logic             sel_slw;
  logic             mem_we;
  logic             busy;
  logic             grant_src;
  logic [CNT_W-1:0] upd_count;

  int checks;
  int failures;

  clause_update_sequencer #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .re_req                       (re_req),
    .slw_req                      (slw_req),
    .hold                         (hold),
    .re_ack                       (re_ack),
    .slw_ack                      (slw_ack),
    .update_from_re_update_module (sel_re),
    .update_from_sliding_window   (sel_slw),
    .mem_we                       (mem_we),
    .busy                         (busy),
    .grant_src                    (grant_src),
    .upd_count                    (upd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {sel_re, sel_slw, mem_we, re_ack, slw_ack, busy} for one sequence granted in cycle s-1.
  function automatic logic [5:0] seq_exp(input int c, input int s, input logic is_re);
    logic sel, we, ack, bsy;
    sel = (c >= s) && (c <= s + 2);
    we  = (c == s + 2);
    ack = (c == s + 3);
    bsy = (c >= s) && (c <= s + 3);
    return {sel & is_re, sel & ~is_re, we, ack & is_re, ack & ~is_re, bsy};
  endfunction

  function automatic logic [5:0] obs();
    return {sel_re, sel_slw, mem_we, re_ack, slw_ack, busy};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    re_req  = 1'b0;
    slw_req = 1'b0;
    hold    = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    re_req  = 1'b0;
    slw_req = 1'b0;
    hold    = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({obs(), grant_src} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000", {obs(), grant_src});
    end
    checks++;
    if (upd_count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", upd_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_slw();
    logic [5:0] want;
    apply_reset();
    slw_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      want = seq_exp(c, 1, 1'b0);
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL single_slw c=%0d got=%b want=%b", c, obs(), want);
      end
      if (slw_ack) slw_req = 1'b0;
    end
    checks++;
    if (upd_count !== 16'd1) begin
      failures++;
      $display("FAIL single_slw_count got=%0d want=1", upd_count);
    end
  endtask

  task automatic test_priority();
    logic [5:0] want;
    apply_reset();
    re_req  = 1'b1;
    slw_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      want = seq_exp(c, 1, 1'b1) | seq_exp(c, 6, 1'b0);
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL priority c=%0d got=%b want=%b", c, obs(), want);
      end
      if (c == 2 || c == 7) begin
        checks++;
        if (grant_src !== (c == 2)) begin
          failures++;
          $display("FAIL priority_grant c=%0d got=%b want=%b", c, grant_src, c == 2);
        end
      end
      if (re_ack)  re_req  = 1'b0;
      if (slw_ack) slw_req = 1'b0;
    end
    checks++;
    if (upd_count !== 16'd2) begin
      failures++;
      $display("FAIL priority_count got=%0d want=2", upd_count);
    end
  endtask

  task automatic test_starve();
    logic [3:0] order;
    logic [3:0] want_order;
    int         acks;
    int         slw_sel_seen;
    apply_reset();
    re_req       = 1'b1;
    slw_req      = 1'b1;
    order        = '0;
    acks         = 0;
    slw_sel_seen = 0;
`ifdef CLAUSE_UPD_FAIR_EN
    want_order = 4'b1010;
`else
    want_order = 4'b1111;
`endif
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      next_cycle();
      if (sel_slw) slw_sel_seen++;
      if (re_ack || slw_ack) begin
        order[3 - acks] = re_ack;
        acks++;
      end
    end
    checks++;
    if (acks !== 4) begin
      failures++;
      $display("FAIL starve_ack_count got=%0d want=4", acks);
    end
    checks++;
    if (order !== want_order) begin
      failures++;
      $display("FAIL starve_order got=%b want=%b (1=RE)", order, want_order);
    end
    checks++;
    if (upd_count !== 16'd4) begin
      failures++;
      $display("FAIL starve_count got=%0d want=4", upd_count);
    end
`ifndef CLAUSE_UPD_FAIR_EN
    checks++;
    if (slw_sel_seen !== 0) begin
      failures++;
      $display("FAIL starve_slw_select got=%0d cycles want=0", slw_sel_seen);
    end
`endif
    re_req  = 1'b0;
    slw_req = 1'b0;
    repeat (6) next_cycle();
  endtask

  task automatic test_hold();
    logic [5:0] want;
    apply_reset();
    hold    = 1'b1;
    slw_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      want = seq_exp(c, 11, 1'b0);
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL hold c=%0d got=%b want=%b", c, obs(), want);
      end
      if (c == 10) hold = 1'b0;
      if (slw_ack) slw_req = 1'b0;
    end
  endtask

  task automatic test_hold_while_busy();
    logic [5:0] want;
    apply_reset();
    slw_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      want = seq_exp(c, 1, 1'b0);
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL hold_busy c=%0d got=%b want=%b", c, obs(), want);
      end
      if (c == 2) hold = 1'b1;
      if (slw_ack) slw_req = 1'b0;
    end
    hold = 1'b0;
  endtask

  task automatic test_early_drop();
    logic [5:0] want;
    apply_reset();
    re_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      want = seq_exp(c, 1, 1'b1);
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL early_drop c=%0d got=%b want=%b", c, obs(), want);
      end
      if (c == 1) re_req = 1'b0;
    end
    checks++;
    if (upd_count !== 16'd1) begin
      failures++;
      $display("FAIL early_drop_count got=%0d want=1", upd_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] want;
    apply_reset();
    slw_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      want = seq_exp(c, 1, 1'b0);
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL reset_mid_pre c=%0d got=%b want=%b", c, obs(), want);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({obs(), upd_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b cnt=%0d want=000000 cnt=0", obs(), upd_count);
    end
    slw_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      checks++;
      if ({obs(), upd_count} !== '0) begin
        failures++;
        $display("FAIL reset_mid_post c=%0d got=%b cnt=%0d want=000000 cnt=0", c, obs(), upd_count);
      end
    end
  endtask

  task automatic test_random();
    int we_cnt, ack_cnt, outstanding, err_excl, err_ack, err_we_sel;
    apply_reset();
    we_cnt      = 0;
    ack_cnt     = 0;
    outstanding = 0;
    err_excl    = 0;
    err_ack     = 0;
    err_we_sel  = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!re_req  && $urandom_range(3) == 0) re_req  = 1'b1;
      if (!slw_req && $urandom_range(3) == 0) slw_req = 1'b1;
      hold = ($urandom_range(7) == 0);
      next_cycle();
      if (sel_re && sel_slw) err_excl++;
      if (mem_we && !(sel_re ^ sel_slw)) err_we_sel++;
      if (mem_we) begin
        we_cnt++;
        outstanding++;
      end
      if (re_ack || slw_ack) begin
        ack_cnt++;
        if (outstanding == 0 || (re_ack && slw_ack)) err_ack++;
        else outstanding--;
      end
      if (re_ack)  re_req  = 1'b0;
      if (slw_ack) slw_req = 1'b0;
    end
    hold = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if (mem_we) we_cnt++;
      if (re_ack || slw_ack) ack_cnt++;
      if (re_ack)  re_req  = 1'b0;
      if (slw_ack) slw_req = 1'b0;
      if (!busy && !re_req && !slw_req) break;
    end
    checks++;
    if (err_excl !== 0) begin
      failures++;
      $display("FAIL random_select_exclusive violations=%0d want=0", err_excl);
    end
    checks++;
    if (err_we_sel !== 0 || err_ack !== 0) begin
      failures++;
      $display("FAIL random_we_ack_protocol we_sel=%0d ack=%0d want=0", err_we_sel, err_ack);
    end
    checks++;
    if (ack_cnt !== we_cnt || we_cnt == 0) begin
      failures++;
      $display("FAIL random_ack_per_we acks=%0d writes=%0d want equal and nonzero", ack_cnt, we_cnt);
    end
    checks++;
    if (upd_count !== CNT_W'(we_cnt)) begin
      failures++;
      $display("FAIL random_count got=%0d want=%0d", upd_count, CNT_W'(we_cnt));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_slw();
    test_priority();
    test_starve();
    test_hold();
    test_hold_while_busy();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
